// File: rtl/emitator_serial.sv
// rtl/emitator_serial.sv - start/data/stop serial emitter with valid/ready word intake
// Optional macro PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module emitator_serial #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] d,
   input  logic              valid,
   output logic              ready,
   output logic              q,
   output logic              qneg,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [BIT_W-1:0]   bit_cnt, bit_next;
   logic [DATA_W-1:0]  shift, shift_next;
   logic               q_next;
   logic               bit_end;
`ifdef PARITY_EN
   logic               par, par_next;
`endif

   assign bit_end = (cnt == CNT_LAST);
   assign ready   = (state == IDLE);
   assign busy    = (state != IDLE);
   assign qneg    = ~q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         q       <= 1'b1;
`ifdef PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_cnt <= bit_next;
         shift   <= shift_next;
         q       <= q_next;
`ifdef PARITY_EN
         par     <= par_next;
`endif
      end
   end

   // q_next is the line level for the cycle after the edge, so q itself stays a plain flop
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      bit_next   = bit_cnt;
      shift_next = shift;
      q_next     = q;
      done       = 1'b0;
`ifdef PARITY_EN
      par_next   = par;
`endif
      if (state != IDLE)
         cnt_next = bit_end ? '0 : cnt + 1'b1;

      case (state)
         IDLE: begin
            q_next = 1'b1;
            if (valid) begin
               state_next = START;
               shift_next = d;
               cnt_next   = '0;
               q_next     = 1'b0;
`ifdef PARITY_EN
               par_next   = ^d;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               state_next = DATA;
               bit_next   = '0;
               q_next     = shift[0];
               shift_next = shift >> 1;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == BIT_LAST) begin
`ifdef PARITY_EN
                  state_next = PARITY;
                  q_next     = par;
`else
                  state_next = STOP;
                  q_next     = 1'b1;
`endif
               end else begin
                  bit_next   = bit_cnt + 1'b1;
                  q_next     = shift[0];
                  shift_next = shift >> 1;
               end
            end
         end
`ifdef PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_next = STOP;
               q_next     = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               done       = 1'b1;
               state_next = IDLE;
               q_next     = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            q_next     = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_emitator_serial.sv
// tb/tb_emitator_serial.sv - randomized self-checking bench for emitator_serial
// Honours PARITY_EN the same way as the design.
module tb_emitator_serial;

   localparam int DATA_W = 8;
   localparam int CPB    = 4;
`ifdef PARITY_EN
   localparam int NBITS  = DATA_W + 3;
`else
   localparam int NBITS  = DATA_W + 2;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] d;
   logic              valid;
   logic              ready, q, qneg, busy, done;

   int checks = 0;
   int errors = 0;

   emitator_serial #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .d(d), .valid(valid),
      .ready(ready), .q(q), .qneg(qneg), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Reference: a frame is a list of line bits, each bit lasting CPB cycles.
   task automatic watch_frame(input logic [DATA_W-1:0] w, input bit scramble, input string tag);
      logic [NBITS-1:0] bits;
      logic exp_q, exp_done;
      bits = '0;
      bits[0] = 1'b0;
      for (int k = 0; k < DATA_W; k++) bits[k+1] = w[k];
`ifdef PARITY_EN
      bits[NBITS-2] = ^w;
`endif
      bits[NBITS-1] = 1'b1;
      for (int i = 0; i < FRAME_CYC; i++) begin
         @(negedge clk);
         exp_q    = bits[i / CPB];
         exp_done = (i == FRAME_CYC - 1);
         checks++;
         if ({q, qneg, busy, ready, done} !== {exp_q, ~exp_q, 1'b1, 1'b0, exp_done}) begin
            errors++;
            $display("FAIL %s cycle %0d word %h: q,qneg,busy,ready,done=%b%b%b%b%b expected %b%b%b%b%b",
                     tag, i + 1, w, q, qneg, busy, ready, done, exp_q, ~exp_q, 1'b1, 1'b0, exp_done);
         end
         if (scramble) begin
            d     = DATA_W'($urandom);
            valid = 1'($urandom);
         end
      end
      if (scramble) valid = 1'b0;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w, input bit scramble, input string tag);
      int n = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_wait: ready=%b required 1 within 100 cycles", tag, ready);
      end
      d = w;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      d = DATA_W'($urandom);
      watch_frame(w, scramble, tag);
      @(negedge clk);
      checks++;
      if ({q, qneg, busy, ready, done} !== 5'b10010) begin
         errors++;
         $display("FAIL %s idle_after: q,qneg,busy,ready,done=%b%b%b%b%b required 10010",
                  tag, q, qneg, busy, ready, done);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      valid = 1'b0;
      d     = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if ({q, qneg, busy, ready, done} !== 5'b10010) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: q,qneg,busy,ready,done=%b%b%b%b%b required 10010",
                     i, q, qneg, busy, ready, done);
         end
      end
   endtask

   task automatic test_known_words;
      send_word(8'hA5, 1'b0, "word_a5");
      send_word(8'h07, 1'b0, "word_07");
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      d = 8'h01;
      valid = 1'b1;
      @(posedge clk);
      #1 d = 8'hFF;
      watch_frame(8'h01, 1'b0, "b2b_first");
      @(negedge clk);
      checks++;
      if ({q, busy, ready} !== 3'b101) begin
         errors++;
         $display("FAIL b2b_gap: q,busy,ready=%b%b%b required 101", q, busy, ready);
      end
      @(posedge clk);
      #1 valid = 1'b0;
      watch_frame(8'hFF, 1'b0, "b2b_second");
      @(negedge clk);
      checks++;
      if ({q, busy, ready} !== 3'b101) begin
         errors++;
         $display("FAIL b2b_end: q,busy,ready=%b%b%b required 101", q, busy, ready);
      end
   endtask

   task automatic test_ignore_valid;
      send_word(8'h3C, 1'b1, "busy_valid");
   endtask

   task automatic test_reset_mid_frame;
      int done_seen = 0;
      @(negedge clk);
      d = 8'hC3;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (18) @(negedge clk);
      checks++;
      if ({q, busy} !== 2'b01) begin
         errors++;
         $display("FAIL mid_bit3: q,busy=%b%b required 01", q, busy);
      end
      reset = 1'b1;
      valid = 1'b1;
      d = DATA_W'($urandom);
      @(posedge clk);
      #1;
      reset = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({q, qneg, busy, ready, done} !== 5'b10010) begin
         errors++;
         $display("FAIL mid_reset: q,qneg,busy,ready,done=%b%b%b%b%b required 10010",
                  q, qneg, busy, ready, done);
      end
      for (int i = 0; i < FRAME_CYC; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL mid_no_done: %0d cycles with done/busy high, required 0", done_seen);
      end
      send_word(8'h5A, 1'b0, "after_reset_5a");
   endtask

   task automatic test_random;
      for (int i = 0; i < 8; i++)
         send_word(DATA_W'($urandom), 1'($urandom), "random");
   endtask

   initial begin
      reset = 1'b1;
      valid = 1'b0;
      d     = '0;
      test_reset;
      test_known_words;
      test_back_to_back;
      test_ignore_valid;
      test_reset_mid_frame;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
